x7seg_capture: RTL and testbench
================================

# x7seg_capture

Receive-side companion to the 4-digit multiplexed seven-segment driver. It samples the active-low segment bus `a_to_g` and anode bus `an`, waits for each scanned pattern to be stable, and decodes it back into four 4-bit hex digits. It also flags illegal patterns and reports frame completion and staleness. It sits in the self-check and loopback path of the ADC display design, tapping the same pins the display driver drives.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synced samples required before a capture; legal range 2..255.
- `TIMEOUT_CYCLES`, default 262144: cycles without any capture before the outputs are declared stale (two full scan frames at the driver's 2^17-cycle frame).
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_to_g` in 7: segment lines, active-low; bit 6 = a … bit 0 = g.
- `an` in 4: anode lines, active-low; `an[i]`=0 selects digit i.
- `led0`..`led3` out 4 each: last legally decoded digit for positions 0..3.
- `dig_valid` out 4: bit i=1 when `led<i>` holds a legal decode that is not stale.
- `frame_done` out 1: one-cycle pulse when all four positions have been captured since the last pulse.
- `seg_err` out 1: one-cycle pulse on the capture of an illegal segment pattern.
- `stale` out 1: level; 1 after `TIMEOUT_CYCLES` cycles without a capture.

## Operation
- **Input synchronizer.** `{an, a_to_g}` passes through 2 flops (s1, s2). A third register `prev` holds the previous s2.
- **Stability counter.** `cnt` resets to 0 when s2≠prev. It increments, saturating at `STABLE_CYCLES`, when s2==prev.
- **Arming.** An `armed` flag is set whenever s2≠prev.
- **Capture condition.** A capture fires in the cycle where all of the following hold:
  - `cnt` reaches `STABLE_CYCLES-1` with s2==prev;
  - `armed`=1;
  - `an` in s2 is exactly one-hot-low.
  A capture clears `armed`. At most one capture occurs per stable period.
- **Ignored anode states.** `an`=1111 (blanking) or more than one low bit never captures and does not clear `armed`.
- **Decode.** Legal patterns are the 16 driver codes:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- **Legal capture for position i.** `led<i>` is set to the decoded value and `dig_valid[i]` is set to 1.
- **Illegal capture.** `led<i>` is held, `dig_valid[i]` is cleared, and `seg_err` pulses.
- **Frame tracking.** Every capture, legal or illegal, sets `seen[i]`. When a capture makes `seen` equal to 1111:
  - `frame_done` pulses;
  - `seen` clears in the same cycle.
- **Timeout.** `tcnt` clears on every capture and otherwise increments, saturating.
  - At `TIMEOUT_CYCLES`, `stale` becomes 1, `dig_valid` becomes 0000, and `seen` clears.
  - The next capture clears `stale`. The captured position's `dig_valid` bit follows the normal decode rule.
- **Reset.** `rst` mid-operation discards any partial stable period and `seen`.

## Timing
- **Reset values:**
  - `led0`..`led3` = 0, `dig_valid` = 0000, `frame_done` = 0, `seg_err` = 0, `stale` = 0;
  - s1, s2 and `prev` = all-ones (blank, no anode);
  - `cnt` = 0, `armed` = 0, `seen` = 0000, `tcnt` = 0.
- **Latency.** If the pins are stable from before edge k onward, capture outputs (`led`, `dig_valid`, `frame_done`, `seg_err`) update at edge k+`STABLE_CYCLES`+2.
- **Glitch rejection.** A pattern that holds for fewer than `STABLE_CYCLES`+1 consecutive sampled cycles is never captured.
- **Simultaneous events.** If a capture and a timeout saturation fall in the same cycle, the capture wins: `stale` stays 0 and `tcnt` clears.
- **Pulse width.** `frame_done` and `seg_err` are exactly 1 cycle and registered. `stale` is registered.

## Structure
- Shared package `x7seg_pkg`, shared with the display driver:
  - the 16 segment-code constants, `SEG_BLANK`, and the anode one-hot constants;
  - a function `seg_is_legal`.
- Sub-module `x7seg_seg2hex`: combinational 7-bit pattern to `{legal, hex[3:0]}` decoder, instantiated once on s2.

## Test plan
- **Reset.** Assert `rst` 3 cycles with random pins → all outputs 0; no capture until 2+`STABLE_CYCLES` cycles after release.
- **Full scan.** Drive `an`=1110/1101/1011/0111 with codes 3, A, 0, F, each held 32768 cycles → `led0..3` = 3, A, 0, F; `dig_valid`=1111; exactly one `frame_done` per 4-digit scan.
- **Glitch rejection.** Hold digit 5 on `an`=1110, insert 3-cycle glitches of 7'b1111111 → glitch not captured; `led0` stays 5; recapture after the glitch, with no `seg_err`.
- **Illegal pattern.** Hold 7'b1010101 on `an`=1011 for 10 cycles after a legal 7 → one `seg_err` pulse; `led2` stays 7; `dig_valid[2]`=0.
- **Stale and recovery.** Stop scanning with `an`=1111 (TIMEOUT_CYCLES=64) → `stale`=1 and `dig_valid`=0000 at cycle 64; a resumed capture of 9 at `an`=1101 → `stale`=0, `led1`=9, `dig_valid`=0010.
- **Held pattern and reset mid-operation.** Hold one pattern 1000 cycles → exactly one capture. Assert `rst` mid-stable-count → no capture from the interrupted period.

Source files
------------

// File: rtl/x7seg_pkg.sv
// x7seg_pkg: segment/anode encodings shared by the seven-segment driver and its capture block.
package x7seg_pkg;
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;
    // Indexed by hex value.
    localparam logic [6:0] SEG_CODES [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                              SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
    typedef struct packed {
        logic       legal;
        logic [3:0] hex;
    } seg_dec_t;
    function automatic logic seg_is_legal(input logic [6:0] seg);
        seg_is_legal = 1'b0;
        for (int k = 0; k < 16; k++) if (seg == SEG_CODES[k]) seg_is_legal = 1'b1;
    endfunction
endpackage

// File: rtl/x7seg_capture_seg2hex.sv
// x7seg_seg2hex: combinational segment pattern to {legal, hex} decoder.
module x7seg_seg2hex
    import x7seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output seg_dec_t   o_dec
);
    always_comb begin
        o_dec.legal = seg_is_legal(i_seg);
        o_dec.hex = 4'h0;
        for (int k = 0; k < 16; k++) if (i_seg == SEG_CODES[k]) o_dec.hex = 4'(k);
    end
endmodule

// File: rtl/x7seg_capture.sv
// x7seg_capture: samples a multiplexed 7-segment bus, waits for stable patterns and decodes
// them back into four hex digits with validity, frame, error and staleness reporting.
module x7seg_capture
    import x7seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] a_to_g,
    input  logic [3:0] an,
    output logic [3:0] led0,
    output logic [3:0] led1,
    output logic [3:0] led2,
    output logic [3:0] led3,
    output logic [3:0] dig_valid,
    output logic       frame_done,
    output logic       seg_err,
    output logic       stale
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [10:0]   r_s1, r_s2, r_prev;
    logic [7:0]    r_cnt;
    logic          r_armed;
    logic [3:0]    r_seen;
    logic [TW-1:0] r_tcnt;
    logic [3:0]    r_led [4];
    seg_dec_t      w_dec;
    logic [3:0]    w_an;
    logic          w_same, w_sel, w_cap, w_timeout;
    logic [1:0]    w_pos;
    logic [3:0]    w_seen_nx;
    logic [TW-1:0] w_tcnt_nx;

    x7seg_seg2hex u_dec (
        .i_seg(r_s2[6:0]),
        .o_dec(w_dec)
    );

    assign w_an = r_s2[10:7];
    assign w_same = r_s2 == r_prev;
    assign w_sel = w_an == AN_D0 || w_an == AN_D1 || w_an == AN_D2 || w_an == AN_D3;
    assign w_pos = w_an == AN_D1 ? 2'd1 : w_an == AN_D2 ? 2'd2 : w_an == AN_D3 ? 2'd3 : 2'd0;
    // armed guarantees a single capture per stable period even if cnt were to revisit S-1.
    assign w_cap = w_same && r_armed && w_sel && r_cnt == 8'(STABLE_CYCLES - 1);
    assign w_seen_nx = r_seen | (4'b0001 << w_pos);
    assign w_tcnt_nx = w_cap ? '0 : r_tcnt == TW'(TIMEOUT_CYCLES) ? r_tcnt : r_tcnt + 1'b1;
    assign w_timeout = w_tcnt_nx == TW'(TIMEOUT_CYCLES);

    assign led0 = r_led[0];
    assign led1 = r_led[1];
    assign led2 = r_led[2];
    assign led3 = r_led[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= {AN_NONE, SEG_BLANK};
            r_s2 <= {AN_NONE, SEG_BLANK};
            r_prev <= {AN_NONE, SEG_BLANK};
            r_cnt <= '0;
            r_armed <= 1'b0;
            r_seen <= '0;
            r_tcnt <= '0;
            for (int k = 0; k < 4; k++) r_led[k] <= '0;
            dig_valid <= '0;
            frame_done <= 1'b0;
            seg_err <= 1'b0;
            stale <= 1'b0;
        end else begin
            r_s1 <= {an, a_to_g};
            r_s2 <= r_s1;
            r_prev <= r_s2;
            r_cnt <= !w_same ? 8'd0 : r_cnt == 8'(STABLE_CYCLES) ? r_cnt : r_cnt + 8'd1;
            r_armed <= !w_same ? 1'b1 : w_cap ? 1'b0 : r_armed;
            r_tcnt <= w_tcnt_nx;
            stale <= w_timeout;
            frame_done <= w_cap && w_seen_nx == 4'hF;
            seg_err <= w_cap && !w_dec.legal;
            if (w_timeout) begin
                dig_valid <= '0;
                r_seen <= '0;
            end
            if (w_cap) begin
                r_seen <= w_seen_nx == 4'hF ? 4'h0 : w_seen_nx;
                dig_valid[w_pos] <= w_dec.legal;
                if (w_dec.legal) r_led[w_pos] <= w_dec.hex;
            end
        end
    end
endmodule

// File: tb/tb_x7seg_capture.sv
// tb_x7seg_capture: randomized and directed stimulus; a run-length reference model feeds a
// capture queue that a per-edge monitor drains and compares against the DUT.
module tb_x7seg_capture;
    localparam int S = 4;
    localparam int TO = 64;
    localparam logic [6:0] CODES [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef struct {
        int         due;
        logic [3:0] a;
        logic [6:0] s;
    } cap_t;

    logic       clk, rst;
    logic [6:0] a_to_g;
    logic [3:0] an;
    logic [3:0] led0, led1, led2, led3, dig_valid;
    logic       frame_done, seg_err, stale;

    int checks = 0, failures = 0;
    int edge_n = 0, run = 0, tc = 0, fd_cnt = 0, se_cnt = 0;
    logic [10:0] last_v = '1;
    bit started = 0;
    cap_t cap_q[$];
    cap_t m_c;
    logic [3:0] m_led [4];
    logic [3:0] m_dv, m_seen;
    logic m_fd, m_se, m_st;
    int m_idx, m_pos;

    x7seg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .a_to_g(a_to_g), .an(an),
        .led0(led0), .led1(led1), .led2(led2), .led3(led3),
        .dig_valid(dig_valid), .frame_done(frame_done), .seg_err(seg_err), .stale(stale)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // A pattern seen on S+1 consecutive edges with one anode low is captured two edges later.
    task automatic drive(input logic r, input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        rst = r;
        an = a;
        a_to_g = s;
        if (r) begin
            last_v = '1;
            run = 0;
        end else begin
            if ({a, s} == last_v) run++;
            else begin
                last_v = {a, s};
                run = 1;
            end
            if (run == S + 1 && $countones(~a) == 1) cap_q.push_back('{edge_n + 3, a, s});
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, a, s);
    endtask

    always @(posedge clk) begin
        #1;
        edge_n++;
        if (rst) begin
            started = 1;
            for (int k = 0; k < 4; k++) m_led[k] = 0;
            m_dv = 0; m_seen = 0; m_fd = 0; m_se = 0; m_st = 0; tc = 0;
            cap_q.delete();
        end else if (started) begin
            m_fd = 0;
            m_se = 0;
            if (cap_q.size() > 0 && cap_q[0].due == edge_n) begin
                m_c = cap_q.pop_front();
                m_idx = -1;
                m_pos = 0;
                for (int k = 0; k < 16; k++) if (m_c.s == CODES[k]) m_idx = k;
                for (int k = 0; k < 4; k++) if (!m_c.a[k]) m_pos = k;
                if (m_idx >= 0) begin
                    m_led[m_pos] = 4'(m_idx);
                    m_dv[m_pos] = 1;
                end else begin
                    m_dv[m_pos] = 0;
                    m_se = 1;
                end
                m_seen[m_pos] = 1;
                if (m_seen == 4'hF) begin
                    m_fd = 1;
                    m_seen = 0;
                end
                tc = 0;
                m_st = 0;
            end else begin
                if (tc < TO) tc++;
                if (tc == TO) begin
                    m_st = 1;
                    m_dv = 0;
                    m_seen = 0;
                end
            end
        end
        if (started) begin
            fd_cnt += int'(frame_done);
            se_cnt += int'(seg_err);
            chk("outputs", {9'd0, led3, led2, led1, led0, dig_valid, frame_done, seg_err, stale},
                {9'd0, m_led[3], m_led[2], m_led[1], m_led[0], m_dv, m_fd, m_se, m_st});
        end
    end

    initial begin
        int fd0, se0, n, k;
        logic [3:0] ra;
        logic [6:0] rs;
        rst = 1; an = '1; a_to_g = '1;
        for (int i = 0; i < 3; i++) drive(1'b1, 4'($urandom), 7'($urandom));
        drive(1'b0, 4'hF, BLANK);
        chk("reset_outputs", {led3, led2, led1, led0, dig_valid, frame_done, seg_err, stale}, 0);
        hold(4'hF, BLANK, 8);
        fd0 = fd_cnt;
        for (int i = 0; i < 3; i++) begin
            hold(4'b1110, CODES[3], 20);
            hold(4'b1101, CODES[10], 20);
            hold(4'b1011, CODES[0], 20);
            hold(4'b0111, CODES[15], 20);
        end
        chk("scan_leds", {led3, led2, led1, led0}, 16'hF0A3);
        chk("scan_valid", dig_valid, 4'hF);
        chk("scan_frames", fd_cnt - fd0, 3);
        se0 = se_cnt;
        hold(4'b1110, CODES[5], 20);
        for (int i = 0; i < 2; i++) begin
            hold(4'b1110, BLANK, 3);
            hold(4'b1110, CODES[5], 20);
        end
        chk("glitch_led0", led0, 5);
        chk("glitch_no_err", se_cnt - se0, 0);
        se0 = se_cnt;
        hold(4'b1011, CODES[7], 20);
        hold(4'b1011, 7'b1010101, 10);
        chk("illegal_err", se_cnt - se0, 1);
        chk("illegal_led2", led2, 7);
        chk("illegal_dv2", dig_valid[2], 0);
        hold(4'hF, BLANK, 70);
        chk("stale_set", stale, 1);
        chk("stale_dv", dig_valid, 0);
        hold(4'b1101, CODES[9], 20);
        chk("recover_stale", stale, 0);
        chk("recover_led1", led1, 9);
        chk("recover_dv", dig_valid, 4'b0010);
        hold(4'b1110, CODES[1], 10);
        hold(4'hF, BLANK, 54);
        hold(4'b1101, CODES[2], 10);
        chk("coincide_stale", stale, 0);
        chk("coincide_led1", led1, 2);
        se0 = se_cnt;
        hold(4'b1110, 7'b1010101, 1000);
        chk("held_once", se_cnt - se0, 1);
        hold(4'b0111, CODES[8], 5);
        drive(1'b1, 4'b0111, CODES[8]);
        drive(1'b1, 4'b0111, CODES[8]);
        hold(4'hF, BLANK, 20);
        chk("midreset_led3", led3, 0);
        chk("midreset_dv", dig_valid, 0);
        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 5);
            ra = k < 4 ? ~(4'b0001 << k) : k == 4 ? 4'hF : 4'($urandom);
            rs = $urandom_range(0, 4) == 0 ? 7'($urandom) : CODES[$urandom_range(0, 15)];
            n = $urandom_range(1, 12);
            if ($urandom_range(0, 49) == 0) begin
                drive(1'b1, ra, rs);
                drive(1'b1, ra, rs);
            end
            hold(ra, rs, n);
        end
        hold(4'hF, BLANK, 10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
